// File: rtl/cla_nibble_serial_sub.sv
// Nibble-serial WIDTH-bit subtractor: a - b - bin through one 4-bit carry-lookahead slice.
// Optional signed-overflow output ovf_out is enabled by defining CLA_SUB_OVF_EN.
module cla_nibble_serial_sub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff_out,
   output logic             bout_out
`ifdef CLA_SUB_OVF_EN
   ,
   output logic             ovf_out
`endif
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   generate
      if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
         $error("cla_nibble_serial_sub: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] bn_p0;
   logic [WIDTH-1:0] res_p0;
   logic             carry_p0;
   logic [IDX_W-1:0] idx_p0;

   logic [4:1]       nib_c;
   logic [3:0]       nib_sum;
   logic [WIDTH+3:0] res_ext;
   logic [WIDTH-1:0] res_next;
   logic             last_nib;

   // Lookahead carries c1..c4 of a 4-bit slice, each a flat generate/propagate term.
   function automatic logic [4:1] cla4_carry(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:1] c;
      g    = a & b;
      p    = a ^ b;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return c;
   endfunction

   assign nib_c    = cla4_carry(a_p0[3:0], bn_p0[3:0], carry_p0);
   assign nib_sum  = (a_p0[3:0] ^ bn_p0[3:0]) ^ {nib_c[3:1], carry_p0};
   // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the LSB.
   assign res_ext  = {nib_sum, res_p0};
   assign res_next = res_ext[WIDTH+3:4];
   assign last_nib = (idx_p0 == IDX_W'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         diff_out <= '0;
         bout_out <= 1'b0;
`ifdef CLA_SUB_OVF_EN
         ovf_out  <= 1'b0;
`endif
         a_p0     <= '0;
         bn_p0    <= '0;
         res_p0   <= '0;
         carry_p0 <= 1'b0;
         idx_p0   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_p0     <= a_in;
                  bn_p0    <= ~b_in;
                  carry_p0 <= ~bin_in;
                  idx_p0   <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_p0     <= a_p0 >> 4;
               bn_p0    <= bn_p0 >> 4;
               res_p0   <= res_next;
               carry_p0 <= nib_c[4];
               idx_p0   <= idx_p0 + IDX_W'(1);
               if (last_nib) begin
                  diff_out <= res_next;
                  bout_out <= ~nib_c[4];
`ifdef CLA_SUB_OVF_EN
                  ovf_out  <= nib_c[3] ^ nib_c[4];
`endif
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_nibble_serial_sub.sv
// Directed bench for cla_nibble_serial_sub: a 16-bit and a 4-bit instance sharing clk/rst.
module tb_cla_nibble_serial_sub;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start4;
   logic [15:0] a_in, b_in;
   logic [3:0]  a4, b4;
   logic        bin_in, bin4;
   logic        busy, done, bout_out;
   logic        busy4, done4, bout4;
   logic [15:0] diff_out;
   logic [3:0]  diff4;
`ifdef CLA_SUB_OVF_EN
   logic        ovf_out, ovf4;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cla_nibble_serial_sub #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .bin_in(bin_in),
      .busy(busy), .done(done), .diff_out(diff_out), .bout_out(bout_out)
`ifdef CLA_SUB_OVF_EN
      , .ovf_out(ovf_out)
`endif
   );

   cla_nibble_serial_sub #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .bin_in(bin4),
      .busy(busy4), .done(done4), .diff_out(diff4), .bout_out(bout4)
`ifdef CLA_SUB_OVF_EN
      , .ovf_out(ovf4)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation on the 16-bit instance, with latency and hold checks.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [15:0] exp_d, input logic exp_b,
                         input logic exp_o);
      int n;
      bit got;
      a_in = a; b_in = b; bin_in = bin; start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy_acc"}, busy, 1'b1);
      n = 0; got = 0;
      while (n < 20 && !got) begin
         tick();
         n++;
         if (done) got = 1;
      end
      chk({tag, "_done_seen"}, got, 1'b1);
      chk({tag, "_latency"}, n, 4);
      chk({tag, "_busy_end"}, busy, 1'b0);
      chk({tag, "_diff"}, diff_out, exp_d);
      chk({tag, "_bout"}, bout_out, exp_b);
`ifdef CLA_SUB_OVF_EN
      chk({tag, "_ovf"}, ovf_out, exp_o);
`else
      if (exp_o === 1'bx) $display("unexpected ovf expectation");
`endif
      tick();
      chk({tag, "_done_drop"}, done, 1'b0);
      chk({tag, "_diff_hold"}, diff_out, exp_d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      bit got;
      rst = 1'b1; start = 1'b0; start4 = 1'b0;
      a_in = 16'h0; b_in = 16'h0; bin_in = 1'b0;
      a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
      tick();
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_diff", diff_out, 16'h0);
      chk("rst_bout", bout_out, 1'b0);
      chk("rst_busy4", busy4, 1'b0);
      rst = 1'b0;
      tick();

      run_op("op_1234", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
      run_op("op_0m1",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);

      // Reset in the second RUN cycle discards the operation and clears the held result.
      a_in = 16'h5555; b_in = 16'h1111; bin_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_diff", diff_out, 16'h0);
      chk("abort_bout", bout_out, 1'b0);
      rst = 1'b0;
      got = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) got = 1;
      end
      chk("abort_no_done", got, 1'b0);
      run_op("op_after_rst", 16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0);

      run_op("op_ff_bin1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      run_op("op_ff_bin0", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
      run_op("op_ovf_neg", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1);
      run_op("op_ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFE, 1'b0, 1'b0);

      // Start held high with operands changing every cycle: accepts at k=0,5,10.
      for (int k = 0; k < 15; k++) begin
         a_in = 16'h0100 + 16'(k);
         b_in = 16'h0001 + 16'(2 * k);
         bin_in = 1'b0;
         start = 1'b1;
         tick();
         chk("hold_done", done, (k % 5) == 4);
         chk("hold_busy", busy, (k % 5) != 4);
         if ((k % 5) == 4) begin
            chk("hold_diff", diff_out, 16'h00FF - 16'(k - 4));
            chk("hold_bout", bout_out, 1'b0);
         end
      end
      start = 1'b0;
      tick();
      chk("hold_idle_busy", busy, 1'b0);
      chk("hold_idle_done", done, 1'b0);

      // 4-bit instance: single-cycle run.
      a4 = 4'h3; b4 = 4'h5; bin4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk("w4_busy_acc", busy4, 1'b1);
      n = 0; got = 0;
      while (n < 10 && !got) begin
         tick();
         n++;
         if (done4) got = 1;
      end
      chk("w4_done_seen", got, 1'b1);
      chk("w4_latency", n, 1);
      chk("w4_diff", diff4, 4'hE);
      chk("w4_bout", bout4, 1'b1);
`ifdef CLA_SUB_OVF_EN
      chk("w4_ovf", ovf4, 1'b0);
`endif
      tick();
      chk("w4_done_drop", done4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
